pc_fetch_ctrl: RTL

//  Owns the PC register and the IF-stage instruction fetch port. Publishes pc to the next-PC generator, takes back npc
//  and redirect (branch/jump/exception/eret flush), issues SRAM-like requests (req/addr_ok/data_ok), discards wrong-path

---
 rtl/pc_fetch_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Owns the fetch PC and the IF-stage SRAM-like instruction port. The current
// pc is published to the next-PC generator, which returns npc (sequential or
// redirect target). One request may be outstanding at a time. Returns that
// belong to a path abandoned by a redirect are dropped. Fetched instructions
// are held in a 2-entry in-order queue that feeds ID.
//
// Ports
//   clk, rst                 clock / synchronous active-high reset
//   pc         (out, 32)     current fetch PC
//   npc        (in, 32)      next PC from the next-PC generator
//   redirect   (in)          npc is non-sequential; flush every fetch in flight
//   pc_wr      (in)          0 = stall: hold pc and issue no new request
//   inst_req   (out)         fetch request valid
//   inst_addr  (out, 32)     fetch address (always pc)
//   inst_addr_ok (in)        request accepted (handshake with inst_req)
//   inst_data_ok (in)        read data returned (one per accepted request)
//   inst_rdata (in, 32)      returned instruction
//   if_valid / if_pc / if_inst / if_adel (out)  queue head towards ID
//   if_ready   (in)          ID consumes the head when if_valid is also high
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        pc_wr,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel,
    input  logic        if_ready
);

    // REQ: may issue. WAIT: one request outstanding on the live path.
    // CANCEL: one request outstanding on an abandoned path. HALT: address
    // error queued, nothing more is fetched until the next redirect.
    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CANCEL = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;          // address of the outstanding request
    logic [31:0] r_q_pc   [2];
    logic [31:0] r_q_inst [2];
    logic [1:0]  r_q_adel;
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;

    logic        w_outstanding;
    logic        w_space;
    logic        w_aligned;
    logic        w_handshake;
    logic        w_enq_data;
    logic        w_enq_adel;
    logic        w_enq;
    logic        w_deq;

    // A request is only issued when its return is guaranteed a queue slot,
    // so the queue can never overflow.
    assign w_outstanding = (r_state == ST_WAIT) || (r_state == ST_CANCEL);
    assign w_space       = ({1'b0, r_cnt} + {2'b00, w_outstanding}) < 3'd2;
    assign w_aligned     = (r_pc[1:0] == 2'b00);
    assign w_handshake   = inst_req & inst_addr_ok;
    assign w_enq         = w_enq_data | w_enq_adel;
    assign w_deq         = if_valid & if_ready;

    assign pc        = r_pc;
    assign inst_addr = r_pc;
    assign if_valid  = (r_cnt != 2'd0);
    assign if_pc     = r_q_pc[r_rp];
    assign if_inst   = r_q_inst[r_rp];
    assign if_adel   = r_q_adel[r_rp];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect takes priority except that a return landing
    // in the same cycle still retires the outstanding request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQ: begin
                if (redirect) begin
                    w_state_nxt = ST_REQ;
                end else if (w_handshake) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_enq_adel) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    w_state_nxt = ST_REQ;
                end else if (redirect) begin
                    w_state_nxt = ST_CANCEL;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_CANCEL: begin
                if (inst_data_ok) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_CANCEL;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase
    end

    // Output logic: request issue and queue-write decisions per state
    always_comb begin
        inst_req   = 1'b0;
        w_enq_data = 1'b0;
        w_enq_adel = 1'b0;
        case (r_state)
            ST_REQ: begin
                inst_req   = pc_wr & ~redirect & w_aligned & w_space & ~rst;
                // A misaligned pc is reported instead of fetched.
                w_enq_adel = pc_wr & ~redirect & ~w_aligned & w_space;
            end
            ST_WAIT: begin
                w_enq_data = inst_data_ok & ~redirect;
            end
            ST_CANCEL: begin
                w_enq_data = 1'b0;
            end
            ST_HALT: begin
                w_enq_data = 1'b0;
            end
            default: begin
                inst_req = 1'b0;
            end
        endcase
    end

    // PC, outstanding address and instruction queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= 32'd0;
            r_q_adel <= 2'b00;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_q_pc[i]   <= 32'd0;
                r_q_inst[i] <= 32'd0;
            end
        end else begin
            if (redirect || w_handshake) begin
                r_pc <= npc;
            end
            if (w_handshake) begin
                r_req_pc <= r_pc;
            end
            if (redirect) begin
                // Flush overrides any same-cycle enqueue or dequeue.
                r_cnt <= 2'd0;
                r_wp  <= 1'b0;
                r_rp  <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_q_pc[r_wp]   <= w_enq_adel ? r_pc : r_req_pc;
                    r_q_inst[r_wp] <= w_enq_adel ? 32'd0 : inst_rdata;
                    r_q_adel[r_wp] <= w_enq_adel;
                    r_wp           <= ~r_wp;
                end
                if (w_deq) begin
                    r_rp <= ~r_rp;
                end
                case ({w_enq, w_deq})
                    2'b10:   r_cnt <= r_cnt + 2'd1;
                    2'b01:   r_cnt <= r_cnt - 2'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

endmodule
